// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch
// Brief   : PC/instruction fetch front-end feeding the lab CPU (in/load/s/w).
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int          AW      = 8,
    parameter logic [15:0] HALT_OP = 16'hE000,
    parameter int          TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic [15:0]   mem_rdata,
    input  logic          cpu_w,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic [15:0]   cpu_in,
    output logic          cpu_load,
    output logic          cpu_s,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_START  = 3'd4;
    localparam logic [2:0] S_BUSY   = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [AW-1:0] r_pc;
    logic [15:0]   r_ir_buf;
    logic [CW-1:0] r_cnt;
    logic          r_halted;
    logic          r_err;
    logic          w_done;
    logic          w_tmo;
    logic          w_is_halt;

    // The CPU may still show w=1 in the first BUSY cycle, so cnt==0 masks it.
    assign w_done    = cpu_w && (r_cnt != '0);
    assign w_tmo     = (r_cnt == CW'(TIMEOUT - 1));
    assign w_is_halt = (mem_rdata == HALT_OP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (go && cpu_w) w_next = S_REQ;
            S_REQ:    w_next = S_DATA;
            S_DATA:   w_next = w_is_halt ? S_HALTED : S_LOAD;
            S_LOAD:   w_next = S_START;
            S_START:  w_next = S_BUSY;
            S_BUSY: begin
                if (w_done) begin
                    w_next = go ? S_REQ : S_IDLE;
                end else if (w_tmo) begin
                    w_next = S_HALTED;
                end
            end
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd   = 1'b0;
        cpu_load = 1'b0;
        cpu_s    = 1'b0;
        unique case (r_state)
            S_REQ:   mem_rd   = 1'b1;
            S_LOAD:  cpu_load = 1'b1;
            S_START: cpu_s    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= '0;
            r_ir_buf <= '0;
            r_cnt    <= '0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            unique case (r_state)
                S_DATA: begin
                    r_ir_buf <= mem_rdata;
                    if (w_is_halt) r_halted <= 1'b1;
                end
                S_START: r_cnt <= '0;
                S_BUSY: begin
                    r_cnt <= r_cnt + CW'(1);
                    // pc is left on the offending word when the watchdog fires.
                    if (w_done) begin
                        r_pc <= r_pc + AW'(1);
                    end else if (w_tmo) begin
                        r_err    <= 1'b1;
                        r_halted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign cpu_in   = r_ir_buf;
    assign halted   = r_halted;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch
// Brief   : Directed self-checking bench for instr_fetch with RAM and CPU models.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [15:0] mem_rdata;
    logic        cpu_w;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] cpu_in;
    logic        cpu_load;
    logic        cpu_s;
    logic [7:0]  pc;
    logic        halted;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [0:255];
    int          exec_cycles;
    bit          hang;
    bit          lag;
    bit          drop_pending;
    int          cpu_cnt;

    instr_fetch #(.AW(8), .HALT_OP(16'hE000), .TIMEOUT(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .mem_rdata (mem_rdata),
        .cpu_w     (cpu_w),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .cpu_in    (cpu_in),
        .cpu_load  (cpu_load),
        .cpu_s     (cpu_s),
        .pc        (pc),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // CPU model: w drops on s (or one cycle late when lag is set) and returns
    // exec_cycles edges later unless hang is set.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_w        <= 1'b1;
            drop_pending <= 1'b0;
            cpu_cnt      <= 0;
        end else if (cpu_s) begin
            cpu_w        <= lag;
            drop_pending <= lag;
            cpu_cnt      <= exec_cycles;
        end else if (drop_pending) begin
            cpu_w        <= 1'b0;
            drop_pending <= 1'b0;
        end else if (!cpu_w && !hang) begin
            if (cpu_cnt <= 1) cpu_w <= 1'b1;
            else              cpu_cnt <= cpu_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        go          = 1'b0;
        hang        = 1'b0;
        lag         = 1'b0;
        exec_cycles = 1;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_s(input int max, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (cpu_s) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_rd(input int max, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (mem_rd) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_pc(input logic [7:0] v, input int max, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (pc == v) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int rds;
        int loads;
        int ss;

        reset       = 1'b0;
        go          = 1'b0;
        hang        = 1'b0;
        lag         = 1'b0;
        exec_cycles = 1;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);

        // Reset state, before any clock edge
        #1;
        check("rst pc", 32'(pc), 32'h0);
        check("rst mem_addr", 32'(mem_addr), 32'h0);
        check("rst strobes", {29'd0, mem_rd, cpu_load, cpu_s}, 32'h0);
        check("rst halted/err", {30'd0, halted, err}, 32'h0);
        check("rst cpu_in", 32'(cpu_in), 32'h0);
        tick();
        tick();
        reset = 1'b1;

        // Basic fetch with latency, then go dropped mid-instruction
        mem[0]      = 16'hD105;
        exec_cycles = 3;
        tick();
        go = 1'b1;
        tick();
        check("req mem_rd", 32'(mem_rd), 32'h1);
        check("req mem_addr", 32'(mem_addr), 32'h0);
        tick();
        check("data strobes", {29'd0, mem_rd, cpu_load, cpu_s}, 32'h0);
        tick();
        check("load strobes", {29'd0, mem_rd, cpu_load, cpu_s}, 32'h2);
        check("load cpu_in", 32'(cpu_in), 32'hD105);
        tick();
        check("start strobes", {29'd0, mem_rd, cpu_load, cpu_s}, 32'h1);
        tick();
        check("busy pc", 32'(pc), 32'h0);
        go = 1'b0;
        tick();
        tick();
        tick();
        check("pc before w", 32'(pc), 32'h0);
        tick();
        check("pc after w", 32'(pc), 32'h1);
        check("mem_addr after w", 32'(mem_addr), 32'h1);
        rds = 0;
        repeat (4) begin
            if (mem_rd) rds++;
            tick();
        end
        check("idle no rd", 32'(rds), 32'h0);
        go = 1'b1;
        tick();
        check("resume mem_rd", 32'(mem_rd), 32'h1);
        check("resume mem_addr", 32'(mem_addr), 32'h1);
        check("cpu_in held", 32'(cpu_in), 32'hD105);

        // HALT encoding on the second word
        do_reset();
        mem[0]      = 16'hD105;
        mem[1]      = 16'hE000;
        exec_cycles = 1;
        go          = 1'b1;
        rds = 0; loads = 0; ss = 0;
        repeat (30) begin
            tick();
            if (mem_rd)   rds++;
            if (cpu_load) loads++;
            if (cpu_s)    ss++;
        end
        check("halt loads", 32'(loads), 32'd1);
        check("halt s", 32'(ss), 32'd1);
        check("halt rds", 32'(rds), 32'd2);
        check("halt flags", {30'd0, halted, err}, 32'h2);
        check("halt pc", 32'(pc), 32'h1);
        check("halt cpu_in", 32'(cpu_in), 32'hE000);
        rds = 0; loads = 0;
        repeat (20) begin
            tick();
            if (mem_rd)   rds++;
            if (cpu_load) loads++;
        end
        check("halt hold activity", 32'(rds + loads), 32'd0);
        check("halt hold pc", 32'(pc), 32'h1);
        check("halt hold flag", 32'(halted), 32'h1);
        mem[1] = 16'h1001;

        // Watchdog expiry 64 cycles after entering BUSY
        do_reset();
        hang = 1'b1;
        go   = 1'b1;
        wait_s(20, "wd s seen");
        tick();
        repeat (63) tick();
        check("wd 63 flags", {30'd0, halted, err}, 32'h0);
        tick();
        check("wd 64 flags", {30'd0, halted, err}, 32'h3);
        check("wd pc", 32'(pc), 32'h0);
        go = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("async clr flags", {30'd0, halted, err}, 32'h0);
        #2;
        hang  = 1'b0;
        reset = 1'b1;

        // Completion on the last watchdog cycle wins
        do_reset();
        exec_cycles = 63;
        go          = 1'b1;
        wait_s(20, "wdb s seen");
        tick();
        repeat (63) tick();
        check("wdb pc pre", 32'(pc), 32'h0);
        tick();
        check("wdb pc", 32'(pc), 32'h1);
        check("wdb flags", {30'd0, halted, err}, 32'h0);

        // w still high in the first BUSY cycle must be ignored
        do_reset();
        exec_cycles = 3;
        lag         = 1'b1;
        go          = 1'b1;
        wait_s(20, "lag s seen");
        tick();
        tick();
        check("lag pc", 32'(pc), 32'h0);
        go = 1'b0;
        wait_pc(8'h01, 20, "lag completes");

        // PC wrap over 256 words
        do_reset();
        exec_cycles = 1;
        go          = 1'b1;
        wait_pc(8'hFE, 2500, "wrap reach FE");
        check("wrap addr FE", 32'(mem_addr), 32'hFE);
        wait_pc(8'hFF, 20, "wrap reach FF");
        check("wrap addr FF", 32'(mem_addr), 32'hFF);
        wait_pc(8'h00, 20, "wrap reach 00");
        check("wrap addr 00", 32'(mem_addr), 32'h00);
        check("wrap flags", {30'd0, halted, err}, 32'h0);

        // Asynchronous reset in the middle of BUSY
        do_reset();
        exec_cycles = 1;
        go          = 1'b1;
        wait_pc(8'h01, 30, "ar reach pc1");
        hang = 1'b1;
        wait_s(20, "ar s seen");
        tick();
        tick();
        check("ar pre pc", 32'(pc), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check("ar pc", 32'(pc), 32'h0);
        check("ar strobes", {29'd0, mem_rd, cpu_load, cpu_s}, 32'h0);
        check("ar flags", {30'd0, halted, err}, 32'h0);
        #2;
        hang  = 1'b0;
        reset = 1'b1;
        wait_rd(20, "ar restart rd");
        check("ar restart addr", 32'(mem_addr), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
